// File: rtl/key_filter.sv
// key_filter: producer side of the OTG_DATA keycode interface.
// Brings the raw USB keycode word into the frame_clk domain, debounces it,
// and presents a stable keycode with press/release/auto-repeat pulses and a
// one-hot direction decode for the ball logic.
module key_filter #(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned REPEAT_DELAY    = 30,
    parameter int unsigned REPEAT_RATE     = 6,
    parameter logic [15:0] KEY_UP          = 16'h001A,
    parameter logic [15:0] KEY_DOWN        = 16'h0016,
    parameter logic [15:0] KEY_LEFT        = 16'h0004,
    parameter logic [15:0] KEY_RIGHT       = 16'h0007
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] OTG_RAW,
    output logic [15:0] OTG_DATA,
    output logic [3:0]  Key_Dir,
    output logic        Key_Press,
    output logic        Key_Release,
    output logic        Key_Repeat
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    // Keep the repeat counter at least one bit wide when both periods are 1.
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StRepeat
    } state_t;

    state_t             state;
    logic [15:0]        raw_s1;
    logic [15:0]        raw_s2;
    logic [15:0]        cand;
    logic [CNT_W-1:0]   cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic               stable;
    logic               cand_zero;

    // Two-flop synchroniser for the asynchronous PIO keycode word.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            raw_s1 <= '0;
            raw_s2 <= '0;
        end else begin
            raw_s1 <= OTG_RAW;
            raw_s2 <= raw_s1;
        end
    end

    // Debounce: restart the count whenever the synced word changes; saturate once stable.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (raw_s2 != cand) begin
            cand <= raw_s2;
            cnt  <= '0;
        end else if (cnt != CNT_STABLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable    = (cnt == CNT_STABLE);
    assign cand_zero = (cand == '0);

    // Key state machine with registered keycode and single-frame pulses.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= StIdle;
            OTG_DATA    <= '0;
            rep_cnt     <= '0;
            Key_Press   <= 1'b0;
            Key_Release <= 1'b0;
            Key_Repeat  <= 1'b0;
        end else begin
            Key_Press   <= 1'b0;
            Key_Release <= 1'b0;
            Key_Repeat  <= 1'b0;
            case (state)
                StIdle: begin
                    if (stable && !cand_zero) begin
                        state     <= StHeld;
                        OTG_DATA  <= cand;
                        Key_Press <= 1'b1;
                        rep_cnt   <= '0;
                    end
                end
                StHeld, StRepeat: begin
                    // Release and rollover take priority over a repeat expiry.
                    if (stable && cand_zero) begin
                        state       <= StIdle;
                        OTG_DATA    <= '0;
                        Key_Release <= 1'b1;
                    end else if (stable && (cand != OTG_DATA)) begin
                        // Rollover to a new key without passing through zero.
                        state     <= StHeld;
                        OTG_DATA  <= cand;
                        Key_Press <= 1'b1;
                        rep_cnt   <= '0;
                    end else if (state == StHeld) begin
                        if (rep_cnt == DELAY_LAST) begin
                            state      <= StRepeat;
                            Key_Repeat <= 1'b1;
                            rep_cnt    <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end else begin
                        if (rep_cnt == RATE_LAST) begin
                            Key_Repeat <= 1'b1;
                            rep_cnt    <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    OTG_DATA <= '0;
                    rep_cnt  <= '0;
                end
            endcase
        end
    end

    // Direction decode; zero and unrecognised keycodes give no direction.
    always_comb begin
        Key_Dir = 4'b0000;
        if (OTG_DATA != '0) begin
            if (OTG_DATA == KEY_UP) begin
                Key_Dir = 4'b0001;
            end else if (OTG_DATA == KEY_DOWN) begin
                Key_Dir = 4'b0010;
            end else if (OTG_DATA == KEY_LEFT) begin
                Key_Dir = 4'b0100;
            end else if (OTG_DATA == KEY_RIGHT) begin
                Key_Dir = 4'b1000;
            end
        end
    end

endmodule

// File: tb/tb_key_filter.sv
// Directed testbench for key_filter at default parameters.
module tb_key_filter;

    logic        frame_clk;
    logic        Reset;
    logic [15:0] OTG_RAW;
    logic [15:0] OTG_DATA;
    logic [3:0]  Key_Dir;
    logic        Key_Press;
    logic        Key_Release;
    logic        Key_Repeat;

    int checks = 0;
    int errors = 0;

    // Per-phase observation state, updated after every edge.
    int edge_no;
    int n_press;
    int n_rel;
    int n_rep;
    int press_edge;
    int rel_edge;
    int nz_data;
    int rep_edges[$];

    key_filter dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .OTG_RAW     (OTG_RAW),
        .OTG_DATA    (OTG_DATA),
        .Key_Dir     (Key_Dir),
        .Key_Press   (Key_Press),
        .Key_Release (Key_Release),
        .Key_Repeat  (Key_Repeat)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        edge_no    = 0;
        n_press    = 0;
        n_rel      = 0;
        n_rep      = 0;
        press_edge = -1;
        rel_edge   = -1;
        nz_data    = 0;
        rep_edges.delete();
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
        edge_no++;
        if (Key_Press) begin
            n_press++;
            press_edge = edge_no;
        end
        if (Key_Release) begin
            n_rel++;
            rel_edge = edge_no;
        end
        if (Key_Repeat) begin
            n_rep++;
            rep_edges.push_back(edge_no);
        end
        if (OTG_DATA != 16'h0000) nz_data++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        Reset   = 1'b1;
        OTG_RAW = 16'h001A;
        clr();

        // Reset with a key already present on the raw input.
        ticks(3);
        chk("rst_data", OTG_DATA, 16'h0000);
        chk("rst_dir", Key_Dir, 4'b0000);
        chk("rst_pulses", {Key_Press, Key_Release, Key_Repeat}, 3'b000);

        Reset = 1'b0;
        clr();
        ticks(5);
        chk("rst_lat_no_press", n_press, 0);
        chk("rst_lat_no_data", OTG_DATA, 16'h0000);
        tick();
        chk("rst_press", Key_Press, 1'b1);
        chk("rst_press_data", OTG_DATA, 16'h001A);
        chk("rst_press_dir", Key_Dir, 4'b0001);
        tick();
        chk("rst_press_1wide", Key_Press, 1'b0);

        // Release of the first key.
        OTG_RAW = 16'h0000;
        clr();
        ticks(6);
        chk("rel1_edge", rel_edge, 6);
        chk("rel1_pulse", Key_Release, 1'b1);
        chk("rel1_data", OTG_DATA, 16'h0000);
        chk("rel1_dir", Key_Dir, 4'b0000);

        // Glitch: key present for only two frames.
        OTG_RAW = 16'h0007;
        clr();
        ticks(2);
        OTG_RAW = 16'h0000;
        ticks(12);
        chk("glitch_press", n_press, 0);
        chk("glitch_rel", n_rel, 0);
        chk("glitch_rep", n_rep, 0);
        chk("glitch_data", nz_data, 0);

        // Hold LEFT for 60 frames; release lands on a repeat expiry.
        OTG_RAW = 16'h0004;
        clr();
        ticks(60);
        chk("hold_press_cnt", n_press, 1);
        chk("hold_press_edge", press_edge, 6);
        chk("hold_data", OTG_DATA, 16'h0004);
        chk("hold_dir", Key_Dir, 4'b0100);
        chk("hold_rep_cnt", n_rep, 5);
        chk("hold_rep0", (rep_edges.size() > 0) ? rep_edges[0] : -1, 36);
        chk("hold_rep1", (rep_edges.size() > 1) ? rep_edges[1] : -1, 42);
        chk("hold_rep2", (rep_edges.size() > 2) ? rep_edges[2] : -1, 48);
        OTG_RAW = 16'h0000;
        ticks(6);
        chk("relrep_edge", rel_edge, 66);
        chk("relrep_release", Key_Release, 1'b1);
        chk("relrep_no_repeat", Key_Repeat, 1'b0);
        chk("relrep_rep_cnt", n_rep, 5);
        chk("relrep_data", OTG_DATA, 16'h0000);
        ticks(40);
        chk("relrep_idle_rep", n_rep, 5);
        chk("relrep_idle_press", n_press, 1);

        // Rollover DOWN -> RIGHT with no zero in between.
        OTG_RAW = 16'h0016;
        clr();
        ticks(6);
        chk("roll_press1", Key_Press, 1'b1);
        chk("roll_data1", OTG_DATA, 16'h0016);
        chk("roll_dir1", Key_Dir, 4'b0010);
        ticks(4);
        OTG_RAW = 16'h0007;
        ticks(5);
        chk("roll_data_hold", OTG_DATA, 16'h0016);
        tick();
        chk("roll_press2", Key_Press, 1'b1);
        chk("roll_press2_edge", press_edge, 16);
        chk("roll_data2", OTG_DATA, 16'h0007);
        chk("roll_dir2", Key_Dir, 4'b1000);
        chk("roll_press_cnt", n_press, 2);
        chk("roll_no_rel", n_rel, 0);
        OTG_RAW = 16'h0000;
        ticks(6);
        chk("roll_rel", Key_Release, 1'b1);
        chk("roll_rel_cnt", n_rel, 1);

        // Reset asserted while auto-repeating UP.
        OTG_RAW = 16'h001A;
        clr();
        ticks(40);
        chk("mid_rep_cnt", n_rep, 1);
        chk("mid_data", OTG_DATA, 16'h001A);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_data", OTG_DATA, 16'h0000);
        chk("mid_rst_dir", Key_Dir, 4'b0000);
        chk("mid_rst_pulses", {Key_Press, Key_Release, Key_Repeat}, 3'b000);
        clr();
        ticks(3);
        chk("mid_rst_no_rel", n_rel, 0);
        Reset = 1'b0;
        clr();
        ticks(5);
        chk("mid_relat_no_press", n_press, 0);
        chk("mid_relat_no_data", OTG_DATA, 16'h0000);
        tick();
        chk("mid_repress", Key_Press, 1'b1);
        chk("mid_repress_data", OTG_DATA, 16'h001A);
        chk("mid_no_rel", n_rel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
